// File: rtl/instruction_fetch_unit.sv
// Bus initiator that fetches instruction words from the instruction memory window,
// splits them into fields and presents them to the execution engine on valid/ready.
module instruction_fetch_unit #(
  parameter logic [3:0]  INSTR_SELECT = 4'h1,
  parameter logic [11:0] START_PC     = 12'h000,
  parameter int unsigned INSTR_DEPTH  = 10,
  parameter logic [7:0]  HALT_OPCODE  = 8'hFF
) (
  input  logic         i_clk,
  input  logic         i_nreset,
  input  logic         i_start,
  output logic [15:0]  o_address,
  output logic         o_nread,
  input  logic [255:0] i_data_in,
  output logic         o_instr_valid,
  input  logic         i_instr_ready,
  output logic [7:0]   o_opcode,
  output logic [7:0]   o_dest,
  output logic [7:0]   o_src1,
  output logic [7:0]   o_src2,
  output logic [11:0]  o_pc,
  output logic         o_busy,
  output logic         o_halted
);

  localparam logic [11:0] LAST_PC = 12'(INSTR_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [15:0] r_address;
  logic        r_nread;
  logic        r_instr_valid;
  logic [7:0]  r_opcode;
  logic [7:0]  r_dest;
  logic [7:0]  r_src1;
  logic [7:0]  r_src2;
  logic [11:0] r_pc;
  logic        r_busy;
  logic        r_halted;

  state_t      w_state_next;
  logic [15:0] w_address_next;
  logic        w_nread_next;
  logic        w_instr_valid_next;
  logic [7:0]  w_opcode_next;
  logic [7:0]  w_dest_next;
  logic [7:0]  w_src1_next;
  logic [7:0]  w_src2_next;
  logic [11:0] w_pc_next;
  logic        w_busy_next;
  logic        w_halted_next;

  logic [11:0] w_pc_inc;
  logic        w_stop;
  logic        w_unused_data;

  // Only the low word of the wide data bus carries an instruction.
  assign w_unused_data = ^i_data_in[255:32];

  assign w_pc_inc = r_pc + 12'd1;
  // End-of-memory is checked before incrementing, so the PC never wraps.
  assign w_stop   = (r_opcode == HALT_OPCODE) || (r_pc == LAST_PC);

  always_comb begin
    w_state_next       = r_state;
    w_address_next     = r_address;
    w_nread_next       = r_nread;
    w_instr_valid_next = r_instr_valid;
    w_opcode_next      = r_opcode;
    w_dest_next        = r_dest;
    w_src1_next        = r_src1;
    w_src2_next        = r_src2;
    w_pc_next          = r_pc;
    w_busy_next        = r_busy;
    w_halted_next      = r_halted;

    case (r_state)
      S_IDLE, S_HALT: begin
        if (i_start) begin
          w_state_next   = S_REQ;
          w_pc_next      = START_PC;
          w_address_next = {INSTR_SELECT, START_PC};
          w_nread_next   = 1'b0;
          w_busy_next    = 1'b1;
          w_halted_next  = 1'b0;
        end
      end

      S_REQ: begin
        // Memory samples the request on this edge; its data appears one edge later.
        w_state_next = S_WAIT;
      end

      S_WAIT: begin
        w_state_next       = S_ISSUE;
        w_opcode_next      = i_data_in[31:24];
        w_dest_next        = i_data_in[23:16];
        w_src1_next        = i_data_in[15:8];
        w_src2_next        = i_data_in[7:0];
        w_instr_valid_next = 1'b1;
        w_nread_next       = 1'b1;
        w_address_next     = 16'h0000;
      end

      S_ISSUE: begin
        if (i_instr_ready) begin
          w_instr_valid_next = 1'b0;
          if (w_stop) begin
            w_state_next  = S_HALT;
            w_busy_next   = 1'b0;
            w_halted_next = 1'b1;
          end else begin
            // Next fetch goes out on the handshake edge itself.
            w_state_next   = S_REQ;
            w_pc_next      = w_pc_inc;
            w_address_next = {INSTR_SELECT, w_pc_inc};
            w_nread_next   = 1'b0;
          end
        end
      end

      default: begin
        w_state_next       = S_IDLE;
        w_address_next     = 16'h0000;
        w_nread_next       = 1'b1;
        w_instr_valid_next = 1'b0;
        w_busy_next        = 1'b0;
        w_halted_next      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state       <= S_IDLE;
      r_address     <= 16'h0000;
      r_nread       <= 1'b1;
      r_instr_valid <= 1'b0;
      r_opcode      <= 8'h00;
      r_dest        <= 8'h00;
      r_src1        <= 8'h00;
      r_src2        <= 8'h00;
      r_pc          <= START_PC;
      r_busy        <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_address     <= w_address_next;
      r_nread       <= w_nread_next;
      r_instr_valid <= w_instr_valid_next;
      r_opcode      <= w_opcode_next;
      r_dest        <= w_dest_next;
      r_src1        <= w_src1_next;
      r_src2        <= w_src2_next;
      r_pc          <= w_pc_next;
      r_busy        <= w_busy_next;
      r_halted      <= w_halted_next;
    end
  end

  assign o_address     = r_address;
  assign o_nread       = r_nread;
  assign o_instr_valid = r_instr_valid;
  assign o_opcode      = r_opcode;
  assign o_dest        = r_dest;
  assign o_src1        = r_src1;
  assign o_src2        = r_src2;
  assign o_pc          = r_pc;
  assign o_busy        = r_busy;
  assign o_halted      = r_halted;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: bus-level instruction memory model plus a
// program-level reference that predicts the sequence of presented instructions.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 10;

  logic         clk;
  logic         nreset;
  logic         start;
  logic [15:0]  address;
  logic         nread;
  logic [255:0] data_in;
  logic         instr_valid;
  logic         instr_ready;
  logic [7:0]   opcode;
  logic [7:0]   dest;
  logic [7:0]   src1;
  logic [7:0]   src2;
  logic [11:0]  pc;
  logic         busy;
  logic         halted;

  logic [31:0]  mem [DEPTH];
  int           n_tests;
  int           n_fail;

  typedef struct {
    logic [11:0] idx;
    logic [31:0] word;
  } instr_t;

  instruction_fetch_unit dut (
    .i_clk        (clk),
    .i_nreset     (nreset),
    .i_start      (start),
    .o_address    (address),
    .o_nread      (nread),
    .i_data_in    (data_in),
    .o_instr_valid(instr_valid),
    .i_instr_ready(instr_ready),
    .o_opcode     (opcode),
    .o_dest       (dest),
    .o_src1       (src1),
    .o_src2       (src2),
    .o_pc         (pc),
    .o_busy       (busy),
    .o_halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: registers the addressed word one edge after a sampled request.
  always @(posedge clk) begin
    if (!nread && address[15:12] == 4'h1) begin
      if (int'(address[11:0]) < DEPTH)
        data_in <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    mem[address[11:0]]};
      else
        data_in <= {224'h0, 32'hDEADBEEF};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one program from Start until Halted, checking every handshake against the
  // list of instructions the program should present, and the bus protocol each cycle.
  task automatic run_program(input bit rand_traffic, output int hs, output int cycles);
    instr_t exp_q[$];
    instr_t e;
    int     run;
    bit     done;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back('{idx: 12'(i), word: mem[i]});
      if (mem[i][31:24] == 8'hFF) break;
    end
    hs = 0;
    run = 0;
    done = 1'b0;
    cycles = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cycles < 2000) begin
      if (!nread) begin
        run++;
        check_eq("req_address", 32'(address), {16'h0, 4'h1, pc});
      end else if (run != 0) begin
        check_eq("nread_low_edges", run, 2);
        run = 0;
      end
      if (halted) begin
        done = 1'b1;
        break;
      end
      instr_ready = rand_traffic ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = rand_traffic ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (instr_valid && instr_ready) begin
        hs++;
        if (exp_q.size() == 0) begin
          check_eq("extra_instr", 32'(pc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("hs_pc", 32'(pc), 32'(e.idx));
          check_eq("hs_fields", {opcode, dest, src1, src2}, e.word);
        end
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    instr_ready = 1'b0;
    check_eq("halted_reached", 32'(done), 32'd1);
    check_eq("instr_left", exp_q.size(), 0);
  endtask

  initial begin
    int hs;
    int cycles;
    logic [11:0] last_idx;
    n_tests = 0;
    n_fail = 0;
    nreset = 1'b0;
    start = 1'b1;
    instr_ready = 1'b0;
    data_in = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;

    // Reset held while clocking with Start high.
    repeat (3) tick();
    check_eq("rst_nread", 32'(nread), 32'd1);
    check_eq("rst_address", 32'(address), 32'h0000);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_pc", 32'(pc), 32'h000);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_fields", {opcode, dest, src1, src2}, 32'h0);
    start = 1'b0;
    nreset = 1'b1;
    repeat (3) tick();
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_nread", 32'(nread), 32'd1);

    // Single fetch of word 0, then backpressure, then stop opcode in word 1.
    mem[0] = 32'h01020001;
    mem[1] = 32'hFF000000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("e0_address", 32'(address), 32'h1000);
    check_eq("e0_nread", 32'(nread), 32'd0);
    tick();
    check_eq("e1_address", 32'(address), 32'h1000);
    check_eq("e1_nread", 32'(nread), 32'd0);
    tick();
    check_eq("e2_nread", 32'(nread), 32'd1);
    check_eq("e2_valid", 32'(instr_valid), 32'd1);
    check_eq("e2_fields", {opcode, dest, src1, src2}, 32'h01020001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_valid", 32'(instr_valid), 32'd1);
      check_eq("bp_fields", {opcode, dest, src1, src2}, 32'h01020001);
      check_eq("bp_pc", 32'(pc), 32'h000);
      check_eq("bp_nread", 32'(nread), 32'd1);
    end
    instr_ready = 1'b1;
    tick();
    check_eq("next_address", 32'(address), 32'h1001);
    check_eq("next_nread", 32'(nread), 32'd0);
    check_eq("next_valid", 32'(instr_valid), 32'd0);
    tick();
    tick();
    check_eq("stop_valid", 32'(instr_valid), 32'd1);
    check_eq("stop_opcode", 32'(opcode), 32'hFF);
    check_eq("stop_pc", 32'(pc), 32'h001);
    tick();
    check_eq("stop_halted", 32'(halted), 32'd1);
    check_eq("stop_pc_after", 32'(pc), 32'h001);
    check_eq("stop_valid_after", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("halt_nread", 32'(nread), 32'd1);
    end
    instr_ready = 1'b0;

    // End of memory: no stop opcode anywhere, ready tied high.
    for (int i = 0; i < DEPTH; i++) mem[i] = {8'(8'h10 + i), 24'($urandom)};
    run_program(1'b0, hs, cycles);
    check_eq("eom_handshakes", hs, DEPTH);
    check_eq("eom_cycles", cycles, 3 * DEPTH);
    check_eq("eom_pc", 32'(pc), 32'h009);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("restart_address", 32'(address), 32'h1000);
    check_eq("restart_nread", 32'(nread), 32'd0);
    check_eq("restart_halted", 32'(halted), 32'd0);

    // Reset dropped while in WAIT.
    tick();
    check_eq("wait_nread", 32'(nread), 32'd0);
    nreset = 1'b0;
    #1;
    check_eq("async_nread", 32'(nread), 32'd1);
    check_eq("async_valid", 32'(instr_valid), 32'd0);
    check_eq("async_address", 32'(address), 32'h0000);
    tick();
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("post_rst_busy", 32'(busy), 32'd0);
      check_eq("post_rst_nread", 32'(nread), 32'd1);
      check_eq("post_rst_halted", 32'(halted), 32'd0);
    end

    // Randomized programs with random backpressure and stray Start pulses.
    for (int t = 0; t < 20; t++) begin
      last_idx = 12'(DEPTH - 1);
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] = $urandom;
        if ($urandom_range(0, 5) == 0) mem[i][31:24] = 8'hFF;
      end
      for (int i = DEPTH - 1; i >= 0; i--)
        if (mem[i][31:24] == 8'hFF) last_idx = 12'(i);
      run_program(1'b1, hs, cycles);
      check_eq("rand_pc", 32'(pc), 32'(last_idx));
      check_eq("rand_handshakes", hs, int'(last_idx) + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
